// File: rtl/aud_pkg.sv
// Shared types and constants for the AUD remote-memory-master arbiter.
package aud_pkg;

  localparam int unsigned AUD_ADDR_W = 32;
  localparam int unsigned AUD_DATA_W = 32;

  // Size codes: beats = 1 << size nibbles
  localparam logic [1:0] AUD_SZ_NIB1 = 2'd0;
  localparam logic [1:0] AUD_SZ_NIB2 = 2'd1;
  localparam logic [1:0] AUD_SZ_NIB4 = 2'd2;
  localparam logic [1:0] AUD_SZ_NIB8 = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitDone,
    StResp
  } aud_arb_state_e;

  function automatic int unsigned aud_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aud_rr_arb.sv
// Round-robin priority pick: first set request searching upward from ptr_i, modulo NUM_REQ.
module aud_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  always_comb begin
    int unsigned k;
    k     = 0;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!vld_o && req_i[k]) begin
        vld_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/aud_rmm_arb.sv
// Round-robin arbiter sharing one aud_rmm between NUM_REQ requesters.
// Define AUD_RMM_ARB_TIMEOUT_EN to enable the per-transaction watchdog and rmm_abort_o.
module aud_rmm_arb
  import aud_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ-1:0]           we_i,
  input  logic [AUD_ADDR_W*NUM_REQ-1:0] addr_i,
  input  logic [AUD_DATA_W*NUM_REQ-1:0] wdata_i,
  input  logic [2*NUM_REQ-1:0]         size_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           ack_o,
  output logic [AUD_DATA_W-1:0]        rdata_o,
  output logic                         err_o,
  output logic                         busy_o,
  output logic [AUD_ADDR_W-1:0]        rmm_addr_o,
  output logic [AUD_DATA_W-1:0]        rmm_data_o,
  output logic [1:0]                   rmm_size_o,
  output logic                         rmm_we_o,
  output logic                         rmm_re_o,
  input  logic [AUD_DATA_W-1:0]        rmm_data_i,
  input  logic                         rmm_err_i,
  input  logic                         rmm_idle_i,
  output logic                         rmm_abort_o
);

  localparam int unsigned IdxW = aud_idx_w(NUM_REQ);

  aud_arb_state_e state_q, state_d;

  logic [IdxW-1:0]       rr_ptr_q, rr_next, owner_q, pick_idx;
  logic [NUM_REQ-1:0]    pick_gnt, owner_oh_q;
  logic                  pick_vld, start, timeout;
  logic                  sel_we, we_q;
  logic [AUD_ADDR_W-1:0] sel_addr, addr_q;
  logic [AUD_DATA_W-1:0] sel_wdata, wdata_q, rdata_q;
  logic [1:0]            sel_size, size_q;
  logic                  err_q, rmm_we_q, rmm_re_q;

  aud_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_arb (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // No grant while the rmm is still busy from elsewhere
  assign start = (state_q == StIdle) && pick_vld && rmm_idle_i;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_size  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_gnt[k]) begin
        sel_we    = we_i[k];
        sel_addr  = addr_i[k*AUD_ADDR_W +: AUD_ADDR_W];
        sel_wdata = wdata_i[k*AUD_DATA_W +: AUD_DATA_W];
        sel_size  = size_i[k*2 +: 2];
      end
    end
  end

  assign rr_next = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);

`ifdef AUD_RMM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        waiting;

  assign waiting = (state_q == StWaitStart) || (state_q == StWaitDone);
  assign timeout = waiting && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (waiting && !timeout) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start) state_d = StIssue;
      StIssue:     state_d = StWaitStart;
      StWaitStart: begin
        if (timeout)          state_d = StResp;
        else if (!rmm_idle_i) state_d = StWaitDone;
      end
      StWaitDone:  if (rmm_idle_i || timeout) state_d = StResp;
      StResp:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Transaction datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      owner_oh_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rmm_we_q   <= 1'b0;
      rmm_re_q   <= 1'b0;
    end else begin
      rmm_we_q <= (state_q == StIssue) && we_q;
      rmm_re_q <= (state_q == StIssue) && !we_q;
      if (start) begin
        owner_q    <= pick_idx;
        owner_oh_q <= pick_gnt;
        we_q       <= sel_we;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        size_q     <= sel_size;
      end
      if ((state_q == StWaitDone) && rmm_idle_i) begin
        rdata_q <= we_q ? '0 : rmm_data_i;
        err_q   <= rmm_err_i;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if (state_q == StResp) rr_ptr_q <= rr_next;
    end
  end

  // Outputs
  always_comb begin
    gnt_o       = '0;
    ack_o       = '0;
    rdata_o     = '0;
    err_o       = 1'b0;
    busy_o      = (state_q != StIdle);
    rmm_abort_o = timeout;
    if (state_q == StIssue) gnt_o = owner_oh_q;
    if (state_q == StResp) begin
      ack_o   = owner_oh_q;
      rdata_o = rdata_q;
      err_o   = err_q;
    end
  end

  assign rmm_addr_o = addr_q;
  assign rmm_data_o = wdata_q;
  assign rmm_size_o = size_q;
  assign rmm_we_o   = rmm_we_q;
  assign rmm_re_o   = rmm_re_q;

endmodule
